// File: rtl/bram_stream_reader.sv
// Read engine for a simple-dual-port BRAM: turns {addr,len} commands into wrapped sequential
// reads on port B and presents the data as a valid/ready stream through a credit-guarded skid FIFO.
module bram_stream_reader #(
  parameter int RAM_WIDTH    = 678,
  parameter int RAM_DEPTH    = 16,
  parameter int READ_LATENCY = 1,
  localparam int AW = $clog2(RAM_DEPTH-1),
  localparam int LW = $clog2(RAM_DEPTH+1)
) (
  input  logic                 clka,
  input  logic                 aresetn,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [AW-1:0]        start_addr,
  input  logic [LW-1:0]        start_len,
  output logic [AW-1:0]        addrb,
  output logic                 enb,
  output logic                 regceb,
  output logic                 rstb,
  input  logic [RAM_WIDTH-1:0] doutb,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);
  localparam int SKID = READ_LATENCY + 1;
  localparam int PW   = (SKID > 1) ? $clog2(SKID) : 1;
  localparam int CW   = $clog2(SKID+1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q;
  logic [AW-1:0]         addr_q, addr_d;
  logic [LW-1:0]         rem_q, len_c;
  logic                  busy_q, done_q, rdy_q;
  logic [READ_LATENCY-1:0] vld_pipe_q, last_pipe_q;
  logic [RAM_WIDTH-1:0]  fifo_data_q [SKID];
  logic [SKID-1:0]       fifo_last_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  push, pop, accept;
  int                    inflight, occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID-1)) ? '0 : p + PW'(1);
  endfunction

  assign push   = vld_pipe_q[READ_LATENCY-1];
  assign pop    = m_valid & m_ready;
  assign accept = start_valid & rdy_q;
  assign len_c  = (start_len > LW'(RAM_DEPTH)) ? LW'(RAM_DEPTH) : start_len;
  assign addr_d = (addr_q == AW'(RAM_DEPTH-1)) ? '0 : addr_q + AW'(1);

  // Credit counts every read that will eventually occupy a FIFO slot, so the FIFO cannot overflow.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LATENCY; i++) inflight += int'(vld_pipe_q[i]);
    occ = int'(cnt_q) + inflight - int'(pop);
  end

  assign enb         = (state_q == S_ISSUE) && (occ < SKID);
  assign addrb       = addr_q;
  assign regceb      = 1'b1;
  assign rstb        = 1'b0;
  assign start_ready = rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign m_valid     = (cnt_q != '0);
  assign m_data      = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last      = m_valid & fifo_last_q[rd_ptr_q];

  always_ff @(posedge clka or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            if (len_c == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= start_addr;
              rem_q   <= len_c;
              busy_q  <= 1'b1;
              rdy_q   <= 1'b0;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (enb) begin
            addr_q <= addr_d;
            rem_q  <= rem_q - LW'(1);
            if (rem_q == LW'(1)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && m_last) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read-return tracking and FIFO bookkeeping; reset discards anything still in flight.
  always_ff @(posedge clka or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      fifo_last_q <= '0;
    end else begin
      vld_pipe_q[0]  <= enb;
      last_pipe_q[0] <= enb && (rem_q == LW'(1));
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      if (push) begin
        fifo_last_q[wr_ptr_q] <= last_pipe_q[READ_LATENCY-1];
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clka) begin
    if (push) fifo_data_q[wr_ptr_q] <= doutb;
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: two instances (depth 16/latency 1, depth 12/latency 2) with BRAM
// models; stimulus pushes expected addresses and beats, a monitor pops and compares them.
module tb_bram_stream_reader;
  localparam int W = 678;
  localparam int D0 = 16, RL0 = 1, D1 = 12, RL1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  logic         rst_n [2];
  logic         sv [2], sr [2];
  logic [3:0]   sa [2];
  logic [4:0]   sl [2];
  logic [3:0]   addrb [2];
  logic         enb [2], regceb [2], rstb [2];
  logic [W-1:0] dout [2], mdata [2];
  logic         mvalid [2], mready [2], mlast [2], busy [2], done [2];

  bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D0), .READ_LATENCY(RL0)) u0 (
    .clka(clk), .aresetn(rst_n[0]), .start_valid(sv[0]), .start_ready(sr[0]),
    .start_addr(sa[0]), .start_len(sl[0]), .addrb(addrb[0]), .enb(enb[0]),
    .regceb(regceb[0]), .rstb(rstb[0]), .doutb(dout[0]), .m_valid(mvalid[0]),
    .m_ready(mready[0]), .m_data(mdata[0]), .m_last(mlast[0]), .busy(busy[0]), .done(done[0]));

  bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D1), .READ_LATENCY(RL1)) u1 (
    .clka(clk), .aresetn(rst_n[1]), .start_valid(sv[1]), .start_ready(sr[1]),
    .start_addr(sa[1]), .start_len(sl[1][3:0]), .addrb(addrb[1]), .enb(enb[1]),
    .regceb(regceb[1]), .rstb(rstb[1]), .doutb(dout[1]), .m_valid(mvalid[1]),
    .m_ready(mready[1]), .m_data(mdata[1]), .m_last(mlast[1]), .busy(busy[1]), .done(done[1]));

  function automatic logic [W-1:0] word(input int k, input int i);
    logic [W-1:0] w;
    w = '0;
    w[31:0] = 32'hC0DE_0000 + 32'(k*256 + i);
    w[W-1 -: 32] = ~w[31:0];
    w[340 +: 16] = 16'(i*3 + 1);
    return w;
  endfunction

  // BRAM models: latency 1 (output straight from array) and latency 2 (extra output register)
  logic [W-1:0] r1;
  always @(posedge clk) if (enb[0]) dout[0] <= word(0, int'(addrb[0]));
  always @(posedge clk) begin
    if (enb[1]) r1 <= word(1, int'(addrb[1]));
    if (regceb[1]) dout[1] <= r1;
  end

  typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
  beat_t qd [2][$];
  int    qa [2][$];
  int    hs_cnt [2], first_hs [2], last_hs [2], rmode [2], rcnt [2];
  logic  stall [2], pl [2];
  logic [W-1:0] pd [2];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic mon(input int k);
    beat_t b;
    if (!rst_n[k]) begin
      stall[k] = 1'b0;
      return;
    end
    if (enb[k]) begin
      if (qa[k].size() == 0) chk("enb_extra", 1, 0);
      else chk("addrb", int'(addrb[k]), qa[k].pop_front());
    end
    if (stall[k]) begin
      chk("hold_valid", int'(mvalid[k]), 1);
      chkd("hold_data", mdata[k], pd[k]);
      chk("hold_last", int'(mlast[k]), int'(pl[k]));
    end
    if (mvalid[k] && mready[k]) begin
      if (qd[k].size() == 0) chk("beat_extra", 1, 0);
      else begin
        b = qd[k].pop_front();
        chkd("data", mdata[k], b.d);
        chk("last", int'(mlast[k]), int'(b.l));
      end
      if (hs_cnt[k] == 0) first_hs[k] = cyc;
      hs_cnt[k]++;
      last_hs[k] = cyc;
    end
    stall[k] = mvalid[k] && !mready[k];
    pd[k] = mdata[k];
    pl[k] = mlast[k];
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  always begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      case (rmode[k])
        1:       mready[k] = ((rcnt[k] % 4) == 0) || ((rcnt[k] % 4) == 3);
        2:       mready[k] = 1'($urandom_range(0, 1));
        default: mready[k] = 1'b1;
      endcase
      rcnt[k]++;
    end
    #1;
    for (int k = 0; k < 2; k++) mon(k);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int k, input int addr, input int len, output int n, output int a);
    int d, t;
    d = (k == 0) ? D0 : D1;
    n = (len > d) ? d : len;
    t = 0;
    while (!sr[k] && t < 50) begin step(); t++; end
    chk("start_ready", int'(sr[k]), 1);
    for (int i = 0; i < n; i++) begin
      qa[k].push_back((addr + i) % d);
      qd[k].push_back('{word(k, (addr + i) % d), (i == n - 1)});
    end
    hs_cnt[k] = 0;
    sv[k] = 1'b1;
    sa[k] = 4'(addr);
    sl[k] = 5'(len);
    a = cyc;
    step();
    sv[k] = 1'b0;
  endtask

  task automatic run_cmd(input int k, input int addr, input int len, input int mode);
    int n, a, t, rl;
    rl = (k == 0) ? RL0 : RL1;
    rmode[k] = mode;
    issue(k, addr, len, n, a);
    if (n == 0) begin
      chk("len0_done", int'(done[k]), 1);
      chk("len0_busy", int'(busy[k]), 0);
      step();
      chk("len0_done_pulse", int'(done[k]), 0);
      return;
    end
    chk("busy_set", int'(busy[k]), 1);
    chk("ready_low", int'(sr[k]), 0);
    t = 0;
    while (!mvalid[k] && t < 50) begin step(); t++; end
    chk("first_valid_cyc", cyc, a + rl + 2);
    t = 0;
    while (!done[k] && t < 400) begin step(); t++; end
    chk("done_seen", int'(done[k]), 1);
    chk("done_cyc", cyc, last_hs[k] + 1);
    chk("busy_clr", int'(busy[k]), 0);
    chk("ready_back", int'(sr[k]), 1);
    chk("beats", hs_cnt[k], n);
    if (mode == 0) chk("b2b_span", last_hs[k] - first_hs[k], n - 1);
    chk("addr_left", qa[k].size(), 0);
    chk("beat_left", qd[k].size(), 0);
    step();
    chk("done_pulse", int'(done[k]), 0);
  endtask

  initial begin
    int n, a;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; sv[k] = 1'b0; sa[k] = '0; sl[k] = '0; mready[k] = 1'b1;
      rmode[k] = 0; rcnt[k] = 0; hs_cnt[k] = 0; stall[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_start_ready", int'(sr[k]), 0);
      chk("rst_enb", int'(enb[k]), 0);
      chk("rst_addrb", int'(addrb[k]), 0);
      chk("rst_valid", int'(mvalid[k]), 0);
      chkd("rst_data", mdata[k], '0);
      chk("rst_busy_done", int'({busy[k], done[k], mlast[k]}), 0);
      chk("regceb_rstb", int'({regceb[k], rstb[k]}), 2);
    end
    @(negedge clk); @(negedge clk);
    #2;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    run_cmd(0, 3, 4, 0);
    run_cmd(0, 14, 4, 0);
    run_cmd(0, 5, 16, 1);
    run_cmd(0, 0, 16, 2);
    run_cmd(0, 7, 0, 0);
    run_cmd(0, 2, 20, 0);

    // Reset in the middle of ISSUE with reads still in flight
    rmode[0] = 0;
    issue(0, 0, 8, n, a);
    step();
    #1;
    rst_n[0] = 1'b0;
    #1;
    chk("mid_rst_enb", int'(enb[0]), 0);
    chk("mid_rst_valid", int'(mvalid[0]), 0);
    chkd("mid_rst_data", mdata[0], '0);
    chk("mid_rst_ctl", int'({busy[0], done[0], mlast[0], sr[0]}), 0);
    chk("mid_rst_addrb", int'(addrb[0]), 0);
    @(negedge clk); @(negedge clk);
    qa[0].delete();
    qd[0].delete();
    #2;
    rst_n[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_valid", int'(mvalid[0]), 0);
    end
    run_cmd(0, 9, 5, 2);

    run_cmd(1, 10, 3, 0);
    run_cmd(1, 4, 12, 1);
    run_cmd(1, 0, 0, 0);
    run_cmd(1, 11, 15, 2);
    run_cmd(1, 6, 12, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
